// File: rtl/maze_loc_stepper.sv
// Location-update datapath for the maze walker: holds the current {X,Y} cell and
// forms the next cell from a one-step move, a popped stack entry, a hold or reset.

module maze_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       en,
  output logic [3:0] res,
  output logic       co
);
  logic [4:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};
  assign res = en ? sum[3:0] : 4'h0;
  assign co  = en ? sum[4] : 1'b0;
endmodule

module maze_mux2 (
  input  logic       sel,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  assign y = sel ? a : b;
endmodule

module maze_reg4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] d,
  output logic [3:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= 4'h0;
    else if (ld)
      q <= d;
  end
endmodule

module maze_loc_stepper (
  input  logic       clk,
  input  logic       rst,
  input  logic       rg_ld,
  input  logic [1:0] dir,
  input  logic       adder_en,
  input  logic       pop,
  input  logic [7:0] pop_loc,
  output logic [7:0] nxt_loc,
  output logic [7:0] cur_loc,
  output logic       cnt_reach,
  output logic       co
);
  logic       sl;
  logic [3:0] operand;
  logic [3:0] increment;
  logic [3:0] res;
  logic [3:0] edge_sum;
  logic [7:0] step_loc;
  logic [7:0] move_loc;
  logic [7:0] pop_sel_loc;

  // X moves for dir 01/10, Y moves for dir 00/11; -1 is added as 4'hF
  assign sl        = dir[1] ^ dir[0];
  assign operand   = sl ? cur_loc[7:4] : cur_loc[3:0];
  assign increment = dir[0] ? 4'h1 : 4'hF;

  maze_adder4 u_adder (
    .a   (operand),
    .b   (increment),
    .en  (adder_en),
    .res (res),
    .co  (co)
  );

  // Edge detect: the coordinate is 15 going up or 0 going down
  assign edge_sum  = operand + {3'b000, dir[0]};
  assign cnt_reach = (edge_sum == 4'h0);

  maze_mux2 u_mux_axis (
    .sel (sl),
    .a   ({res, cur_loc[3:0]}),
    .b   ({cur_loc[7:4], res}),
    .y   (step_loc)
  );

  maze_mux2 u_mux_step (
    .sel (adder_en),
    .a   (step_loc),
    .b   (cur_loc),
    .y   (move_loc)
  );

  maze_mux2 u_mux_pop (
    .sel (pop),
    .a   (pop_loc),
    .b   (move_loc),
    .y   (pop_sel_loc)
  );

  maze_mux2 u_mux_rst (
    .sel (rst),
    .a   (8'h00),
    .b   (pop_sel_loc),
    .y   (nxt_loc)
  );

  // Index 0 holds Y (bits 3:0), index 1 holds X (bits 7:4)
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_coord_reg
      maze_reg4 u_reg (
        .clk (clk),
        .rst (rst),
        .ld  (rg_ld),
        .d   (nxt_loc[gi*4 +: 4]),
        .q   (cur_loc[gi*4 +: 4])
      );
    end
  endgenerate
endmodule

// File: tb/tb_maze_loc_stepper.sv
// Self-checking bench for maze_loc_stepper: directed cases with literal expectations
// plus randomized traffic compared every cycle against a coordinate-level model.

module tb_maze_loc_stepper;
  logic       clk;
  logic       rst;
  logic       rg_ld;
  logic [1:0] dir;
  logic       adder_en;
  logic       pop;
  logic [7:0] pop_loc;
  logic [7:0] nxt_loc;
  logic [7:0] cur_loc;
  logic       cnt_reach;
  logic       co;

  int tests = 0;
  int fails = 0;
  logic [7:0] m_loc;

  maze_loc_stepper dut (
    .clk       (clk),
    .rst       (rst),
    .rg_ld     (rg_ld),
    .dir       (dir),
    .adder_en  (adder_en),
    .pop       (pop),
    .pop_loc   (pop_loc),
    .nxt_loc   (nxt_loc),
    .cur_loc   (cur_loc),
    .cnt_reach (cnt_reach),
    .co        (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: work on integer coordinates; dir 00 = Y-1, 01 = X+1, 10 = X-1, 11 = Y+1
  function automatic int moving_coord(input logic [7:0] loc, input logic [1:0] d);
    int x;
    int y;
    x = int'(loc[7:4]);
    y = int'(loc[3:0]);
    return (d == 2'b01 || d == 2'b10) ? x : y;
  endfunction

  function automatic logic going_up(input logic [1:0] d);
    return (d == 2'b01 || d == 2'b11);
  endfunction

  function automatic logic [7:0] model_nxt(input logic [7:0] loc, input logic r,
                                           input logic p, input logic [7:0] pl,
                                           input logic ae, input logic [1:0] d);
    int x;
    int y;
    x = int'(loc[7:4]);
    y = int'(loc[3:0]);
    if (r) return 8'h00;
    if (p) return pl;
    if (!ae) return loc;
    case (d)
      2'b00:   y = (y + 15) % 16;
      2'b01:   x = (x + 1) % 16;
      2'b10:   x = (x + 15) % 16;
      default: y = (y + 1) % 16;
    endcase
    return 8'((x * 16) + y);
  endfunction

  function automatic logic model_edge(input logic [7:0] loc, input logic [1:0] d);
    int c;
    c = moving_coord(loc, d);
    return going_up(d) ? (c == 15) : (c == 0);
  endfunction

  // Adding 1 carries only out of 15; adding 15 (i.e. -1) carries unless the coord is 0
  function automatic logic model_co(input logic [7:0] loc, input logic ae, input logic [1:0] d);
    int c;
    c = moving_coord(loc, d);
    if (!ae) return 1'b0;
    return going_up(d) ? (c == 15) : (c != 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)
      m_loc <= 8'h00;
    else if (rg_ld)
      m_loc <= model_nxt(m_loc, 1'b0, pop, pop_loc, adder_en, dir);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_cur_loc", cur_loc, m_loc);
    chk("cyc_nxt_loc", nxt_loc, model_nxt(m_loc, rst, pop, pop_loc, adder_en, dir));
    chk("cyc_cnt_reach", {7'b0, cnt_reach}, {7'b0, model_edge(m_loc, dir)});
    chk("cyc_co", {7'b0, co}, {7'b0, model_co(m_loc, adder_en, dir)});
  end

  task automatic drive(input logic l, input logic [1:0] d, input logic ae,
                       input logic p, input logic [7:0] pl);
    rg_ld = l;
    dir = d;
    adder_en = ae;
    pop = p;
    pop_loc = pl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] loc);
    drive(1'b1, 2'b00, 1'b0, 1'b1, loc);
    tick();
    $display("[TB] load %h -> cur_loc %h", loc, cur_loc);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
    #2;
    chk("rst_cur", cur_loc, 8'h00);
    chk("rst_nxt", nxt_loc, 8'h00);
    chk("rst_cnt_dec", {7'b0, cnt_reach}, 8'h01);
    chk("rst_co", {7'b0, co}, 8'h00);
    dir = 2'b01;
    #1;
    chk("rst_cnt_inc", {7'b0, cnt_reach}, 8'h00);
    dir = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("hold_zero", cur_loc, 8'h00);

    // Asynchronous clear in the middle of a cycle
    load(8'h5A);
    chk("load_5a", cur_loc, 8'h5A);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_cur", cur_loc, 8'h00);
    chk("async_rst_nxt", nxt_loc, 8'h00);
    #1;
    rst = 1'b0;
    tick();

    drive(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
    #1;
    chk("step_x_nxt", nxt_loc, 8'h10);
    chk("step_x_co", {7'b0, co}, 8'h00);
    chk("step_x_cnt", {7'b0, cnt_reach}, 8'h00);
    tick();
    chk("step_x_cur", cur_loc, 8'h10);
    drive(1'b1, 2'b11, 1'b1, 1'b0, 8'h00);
    tick();
    chk("step_y_cur", cur_loc, 8'h11);
    $display("[TB] steps X+1,Y+1 -> cur_loc %h", cur_loc);

    load(8'h33);
    drive(1'b0, 2'b10, 1'b1, 1'b0, 8'h00);
    #1;
    chk("xdec_nxt", nxt_loc, 8'h23);
    chk("xdec_co", {7'b0, co}, 8'h01);
    dir = 2'b00;
    #1;
    chk("ydec_nxt", nxt_loc, 8'h32);
    chk("ydec_co", {7'b0, co}, 8'h01);

    load(8'hF0);
    drive(1'b0, 2'b01, 1'b1, 1'b0, 8'h00);
    #1;
    chk("f0_xinc_cnt", {7'b0, cnt_reach}, 8'h01);
    chk("f0_xinc_nxt", nxt_loc, 8'h00);
    dir = 2'b00;
    #1;
    chk("f0_ydec_cnt", {7'b0, cnt_reach}, 8'h01);
    chk("f0_ydec_nxt", nxt_loc, 8'hFF);
    load(8'h0F);
    drive(1'b0, 2'b11, 1'b1, 1'b0, 8'h00);
    #1;
    chk("0f_yinc_cnt", {7'b0, cnt_reach}, 8'h01);
    dir = 2'b10;
    #1;
    chk("0f_xdec_cnt", {7'b0, cnt_reach}, 8'h01);
    load(8'h77);
    drive(1'b0, 2'b00, 1'b1, 1'b0, 8'h00);
    for (int d = 0; d < 4; d++) begin
      dir = 2'(d);
      #1;
      chk("77_cnt", {7'b0, cnt_reach}, 8'h00);
    end

    load(8'h12);
    drive(1'b1, 2'b01, 1'b1, 1'b1, 8'hA5);
    #1;
    chk("pop_prio_nxt", nxt_loc, 8'hA5);
    tick();
    chk("pop_prio_cur", cur_loc, 8'hA5);

    load(8'h44);
    drive(1'b0, 2'b01, 1'b1, 1'b0, 8'h00);
    #1;
    chk("noload_nxt", nxt_loc, 8'h54);
    tick();
    chk("noload_cur", cur_loc, 8'h44);
    drive(1'b0, 2'b01, 1'b0, 1'b0, 8'h00);
    #1;
    chk("idle_nxt", nxt_loc, 8'h44);
    chk("idle_co", {7'b0, co}, 8'h00);
    tick();

    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(3) != 0), 2'($urandom_range(3)), 1'($urandom_range(1)),
            ($urandom_range(7) == 0), 8'($urandom_range(255)));
      rst = ($urandom_range(63) == 0);
      tick();
      if (i % 250 == 0)
        $display("[TB] random cycle %0d cur_loc %h model %h", i, cur_loc, m_loc);
    end
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
